// File: rtl/mc_pkg.sv
// Shared types for the mc_sched burst scheduler: FSM states and the complex sample word.
package mc_pkg;
  localparam int MC_DW = 16;

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_e;

  typedef struct packed {
    logic [MC_DW-1:0] re;
    logic [MC_DW-1:0] im;
  } sample_t;
endpackage

// File: rtl/mc_rr_arb.sv
// Combinational round-robin arbiter; the search starts one past the previous owner.
module mc_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_gnt,
  output logic [IDW-1:0]  gnt,
  output logic            gnt_vld
);
  logic [IDW-1:0] idx;

  // NREQ is a power of two, so the id wraps by truncation; i == NREQ lands on last_gnt itself
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last_gnt + IDW'(i);
      if (!gnt_vld && req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mc_sched.sv
// Shares one MC core among NREQ requesters: grant, buffer a LEN-sample burst,
// replay it contiguously, and route the LEN results back tagged with the owner id.
module mc_sched
  import mc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LEN     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         src_valid,
  output logic [NREQ-1:0]         src_ready,
  input  logic [MC_DW*NREQ-1:0]   src_x_real,
  input  logic [MC_DW*NREQ-1:0]   src_x_img,
  output logic                    mc_in_valid,
  output logic [MC_DW-1:0]        mc_x_real,
  output logic [MC_DW-1:0]        mc_x_img,
  input  logic                    mc_out_valid,
  input  logic [MC_DW-1:0]        mc_y_real,
  input  logic [MC_DW-1:0]        mc_y_img,
  output logic                    dst_valid,
  output logic [$clog2(NREQ)-1:0] dst_id,
  output logic [MC_DW-1:0]        dst_y_real,
  output logic [MC_DW-1:0]        dst_y_img,
  output logic                    dst_last,
  output logic                    busy,
  output logic                    err_timeout
);
  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(LEN);
  localparam int CW  = $clog2(LEN + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_e                       state, state_nx;
  logic [IDW-1:0]               gnt, last_gnt, arb_gnt;
  logic                         arb_vld;
  logic [CW-1:0]                ld_cnt, fd_cnt, out_cnt;
  logic [TW-1:0]                to_cnt;
  logic [NREQ-1:0][MC_DW-1:0]   src_re, src_im;
  sample_t                      src_smp;
  sample_t                      smp_buf [LEN];
  logic                         xfer, accept, to_hit;

  mc_rr_arb #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .gnt_vld  (arb_vld)
  );

  assign src_re  = src_x_real;
  assign src_im  = src_x_img;
  assign src_smp = '{re: src_re[gnt], im: src_im[gnt]};

  assign xfer   = (state == LOAD) && src_valid[gnt];
  // results are taken from the first FEED cycle on; anything past LEN is dropped
  assign accept = mc_out_valid && (state == FEED || state == DRAIN) && (out_cnt < CW'(LEN));
  assign to_hit = (state == DRAIN) && !mc_out_valid && (to_cnt == TW'(TIMEOUT - 1));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    src_ready   = '0;
    mc_in_valid = 1'b0;
    mc_x_real   = '0;
    mc_x_img    = '0;
    unique case (state)
      IDLE: if (arb_vld) state_nx = LOAD;
      LOAD: begin
        src_ready[gnt] = 1'b1;
        if (xfer && ld_cnt == LAST) state_nx = FEED;
      end
      FEED: begin
        mc_in_valid = 1'b1;
        mc_x_real   = smp_buf[fd_cnt[AW-1:0]].re;
        mc_x_img    = smp_buf[fd_cnt[AW-1:0]].im;
        if (fd_cnt == LAST) state_nx = DRAIN;
      end
      DRAIN: if (out_cnt == CW'(LEN) || (accept && out_cnt == LAST) || to_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt         <= '0;
      last_gnt    <= IDW'(NREQ - 1);
      ld_cnt      <= '0;
      fd_cnt      <= '0;
      out_cnt     <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
      dst_valid   <= 1'b0;
      dst_last    <= 1'b0;
      dst_id      <= '0;
      dst_y_real  <= '0;
      dst_y_img   <= '0;
    end else begin
      if (state == IDLE && arb_vld) gnt <= arb_gnt;
      if (xfer) ld_cnt <= (ld_cnt == LAST) ? '0 : ld_cnt + 1'b1;
      if (state == FEED) fd_cnt <= (fd_cnt == LAST) ? '0 : fd_cnt + 1'b1;
      if (state == IDLE)  out_cnt <= '0;
      else if (accept)    out_cnt <= out_cnt + 1'b1;
      // priority only advances once the burst is finished or abandoned
      if (state == DRAIN && state_nx == IDLE) begin
        last_gnt <= gnt;
        to_cnt   <= '0;
      end else if (state == DRAIN) begin
        to_cnt <= mc_out_valid ? '0 : to_cnt + 1'b1;
      end
      err_timeout <= to_hit;
      dst_valid   <= accept;
      dst_last    <= accept && (out_cnt == LAST);
      if (accept) begin
        dst_id     <= gnt;
        dst_y_real <= mc_y_real;
        dst_y_img  <= mc_y_img;
      end
    end
  end

  // sample store needs no reset: contents are always rewritten before replay
  always_ff @(posedge clk) begin
    if (xfer) smp_buf[ld_cnt[AW-1:0]] <= src_smp;
  end
endmodule

// File: tb/tb_mc_sched.sv
// Directed bench for mc_sched: requester sources, a model core that echoes
// swapped samples, and a monitor logging grants and forwarded results.
module tb_mc_sched;
  localparam int NREQ = 4, LEN = 16, TIMEOUT = 1024, CLK_P = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, src_valid = '0, src_ready;
  logic [NREQ-1:0][15:0] src_xr = '0, src_xi = '0;
  logic mc_in_valid, mc_out_valid;
  logic [15:0] mc_x_real, mc_x_img;
  logic core_ov = 1'b0, stray_ov = 1'b0;
  logic [15:0] core_yr = '0, core_yi = '0;
  logic dst_valid, dst_last, busy, err_timeout;
  logic [1:0] dst_id;
  logic [15:0] dst_y_real, dst_y_img;
  int checks = 0, failures = 0;

  always #(CLK_P/2) clk = ~clk;
  assign mc_out_valid = core_ov | stray_ov;

  mc_sched #(.NREQ(NREQ), .LEN(LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_ready(src_ready),
    .src_x_real(src_xr), .src_x_img(src_xi),
    .mc_in_valid(mc_in_valid), .mc_x_real(mc_x_real), .mc_x_img(mc_x_img),
    .mc_out_valid(mc_out_valid), .mc_y_real(core_yr), .mc_y_img(core_yi),
    .dst_valid(dst_valid), .dst_id(dst_id), .dst_y_real(dst_y_real), .dst_y_img(dst_y_img),
    .dst_last(dst_last), .busy(busy), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // sources: lane i sends x = (i*256+k) + j(-(i*256+k)); optional gap every third cycle
  logic [NREQ-1:0] src_en = '0;
  bit gap = 1'b0;
  int cyc = 0;
  int scnt [NREQ];
  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      src_valid[i] = src_en[i] && !(gap && (cyc % 3 == 0));
      src_xr[i]    = 16'(i*256 + scnt[i]);
      src_xi[i]    = 16'(-(i*256 + scnt[i]));
      if (src_valid[i] && src_ready[i]) scnt[i]++;
    end
  end

  // model core: logs inputs, returns core_n results y = x_img + j x_real starting core_lat cycles into FEED
  int core_lat = 18, core_n = 16, c_cyc = -1, c_sent = 0;
  logic prev_inv = 1'b0;
  logic [15:0] xq_r[$], xq_i[$], in_xr[$], in_xi[$];
  time in_tf = 0, in_tl = 0;
  initial forever begin
    @(negedge clk);
    if (mc_in_valid) begin
      if (!prev_inv) begin
        c_cyc = 0; c_sent = 0; xq_r.delete(); xq_i.delete(); in_tf = $time;
      end
      xq_r.push_back(mc_x_real); xq_i.push_back(mc_x_img);
      in_xr.push_back(mc_x_real); in_xi.push_back(mc_x_img);
      in_tl = $time;
    end
    prev_inv = mc_in_valid;
    core_ov = 1'b0;
    if (c_cyc >= 0) begin
      if (c_cyc >= core_lat && c_sent < core_n && xq_r.size() > 0) begin
        core_ov = 1'b1; core_yr = xq_i.pop_front(); core_yi = xq_r.pop_front(); c_sent++;
      end
      c_cyc++;
    end
  end

  // monitor
  logic [1:0] d_id[$];
  logic [15:0] d_yr[$], d_yi[$];
  time d_t[$], to_t[$];
  int last_at[$], g_log[$];
  int lasts = 0, last_busy = 0, ready_bad = 0;
  logic [NREQ-1:0] rdy_prev = '0;
  initial forever begin
    @(negedge clk);
    if (dst_valid) begin
      d_id.push_back(dst_id); d_yr.push_back(dst_y_real); d_yi.push_back(dst_y_img);
      d_t.push_back($time);
      if (dst_last) begin
        lasts++; last_at.push_back(d_id.size());
        if (busy) last_busy++;
      end
    end
    if (err_timeout) to_t.push_back($time);
    if (src_ready != '0 && rdy_prev == '0)
      for (int i = 0; i < NREQ; i++) if (src_ready[i]) g_log.push_back(i);
    if (!$onehot0(src_ready)) ready_bad++;
    rdy_prev = src_ready;
  end

  initial begin
    #(CLK_P * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    d_id.delete(); d_yr.delete(); d_yi.delete(); d_t.delete(); to_t.delete();
    last_at.delete(); in_xr.delete(); in_xi.delete(); xq_r.delete(); xq_i.delete();
  endtask

  task automatic wait_grant(input int g, input string tag);
    int n0 = g_log.size();
    int k = 0;
    while (g_log.size() == n0 && k < 100) begin tick(); k++; end
    chk({tag, "_gnt"}, (g_log.size() > n0) ? g_log[n0] : 99, g);
  endtask

  task automatic wait_lasts(input int n, input int budget, input string tag);
    int tgt = lasts + n;
    int k = 0;
    while (lasts < tgt && k < budget) begin tick(); k++; end
    chk({tag, "_done"}, lasts >= tgt, 1);
  endtask

  int base_q;
  task automatic one_burst(input int g, input int lat, input int n_out, input bit gp, input string tag);
    clr();
    core_lat = lat; core_n = n_out; gap = gp;
    base_q = scnt[g];
    src_en = '0; src_en[g] = 1'b1;
    req = '0; req[g] = 1'b1;
    wait_grant(g, tag);
    req = '0;
  endtask

  task automatic check_burst(input int g, input int base, input string tag);
    int v, bad_id;
    chk({tag, "_nin"}, in_xr.size(), LEN);
    chk({tag, "_contig"}, in_tl - in_tf, (LEN-1)*CLK_P);
    for (int k = 0; k < in_xr.size(); k++) begin
      v = g*256 + base + k;
      chk({tag, "_x"}, {in_xr[k], in_xi[k]}, {16'(v), 16'(-v)});
    end
    chk({tag, "_ndst"}, d_id.size(), LEN);
    bad_id = 0;
    for (int k = 0; k < d_id.size(); k++) begin
      v = g*256 + base + k;
      chk({tag, "_y"}, {d_yr[k], d_yi[k]}, {16'(-v), 16'(v)});
      if (d_id[k] != 2'(g)) bad_id++;
    end
    chk({tag, "_id"}, bad_id, 0);
    chk({tag, "_lastpos"}, last_at.size() == 1 && last_at[0] == LEN, 1);
  endtask

  initial begin
    int kf, n;
    repeat (3) tick();
    chk("rst_ctl", {busy, src_ready, mc_in_valid, dst_valid, dst_last, err_timeout}, '0);
    chk("rst_mcx", {mc_x_real, mc_x_img}, '0);
    chk("rst_dst", {dst_id, dst_y_real, dst_y_img}, '0);
    rst = 1'b0;
    tick();

    // round robin: all requesting, 8 bursts
    clr(); src_en = '1; req = '1;
    wait_lasts(8, 900, "rr");
    req = '0; src_en = '0;
    chk("rr_ngnt", g_log.size(), 8);
    for (int b = 0; b < 8 && b < g_log.size(); b++) chk("rr_gnt", g_log[b], b % 4);
    chk("rr_ndst", d_id.size(), 8*LEN);
    for (int b = 0; b < 8 && 16*b < d_id.size(); b++) chk("rr_id", d_id[16*b], b % 4);
    if (d_id.size() > 64) chk("rr_data", {d_yr[64], d_yi[64]}, {16'(-16), 16'(16)});

    // single burst from requester 2 with source gaps
    one_burst(2, 18, 16, 1'b1, "t1");
    wait_lasts(1, 200, "t1");
    check_burst(2, base_q, "t1");

    // core returns only 5 results: timeout, then a clean re-grant of the same requester
    one_burst(3, 18, 5, 1'b0, "t4");
    n = 0;
    while (to_t.size() == 0 && n < 1300) begin tick(); n++; end
    chk("t4_idle", busy, 0);
    chk("t4_ndst", d_id.size(), 5);
    chk("t4_nolast", last_at.size(), 0);
    chk("t4_delay", ((to_t.size() > 0) ? to_t[0] : 0) - ((d_t.size() > 4) ? d_t[4] : 0), TIMEOUT*CLK_P);
    tick(); tick();
    chk("t4_pulse", to_t.size(), 1);
    one_burst(3, 18, 16, 1'b0, "t4b");
    wait_lasts(1, 200, "t4b");
    check_burst(3, base_q, "t4b");
    chk("t4b_noto", to_t.size(), 0);

    // early results, starting at FEED index 10
    one_burst(1, 10, 16, 1'b0, "t3");
    wait_lasts(1, 200, "t3");
    check_burst(1, base_q, "t3");
    chk("t3_early", (d_t.size() > 0) && (d_t[0] < in_tl), 1);

    // reset at FEED index 7, then all requesting: id 0 must win
    one_burst(2, 18, 16, 1'b0, "t5");
    kf = 0; n = 0;
    while (kf < 8 && n < 200) begin tick(); n++; if (mc_in_valid) kf++; end
    chk("t5_infeed", kf, 8);
    rst = 1'b1;
    #1;
    chk("t5_ctl", {busy, src_ready, mc_in_valid, dst_valid, dst_last, err_timeout}, '0);
    chk("t5_mcx", {mc_x_real, mc_x_img}, '0);
    chk("t5_dst", {dst_id, dst_y_real, dst_y_img}, '0);
    tick();
    rst = 1'b0;
    clr();
    base_q = scnt[0];
    src_en = '1; req = '1;
    wait_grant(0, "t5b");
    req = '0;
    wait_lasts(1, 200, "t5b");
    src_en = '0;
    check_burst(0, base_q, "t5b");

    // stray core output while idle
    clr();
    tick();
    stray_ov = 1'b1;
    repeat (3) tick();
    stray_ov = 1'b0;
    repeat (2) tick();
    chk("t6_stray", d_id.size(), 0);
    chk("t6_idle", busy, 0);

    chk("ready_onehot", ready_bad, 0);
    chk("busy_at_last", last_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_sched.md
# mc_sched

Burst scheduler that shares one `MC` Monte-Carlo core among `NREQ` requesters.
- Round-robin grants one requester at a time.
- Buffers that requester's `LEN` complex samples, which may arrive with gaps.
- Replays them to the core as one contiguous `in_valid` burst.
- Routes the core's `LEN` results back, tagged with the requester id.
- Sits between the requester fabric and the single `MC` instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (power of two, ≥2).
- `LEN`, 16: samples per burst, and results expected per burst.
- `TIMEOUT`, 1024: maximum DRAIN cycles with no core output.

Ports (flattened buses, lane i = bits [16i+15:16i]):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  requester i has a burst pending.
- `src_valid`  in  NREQ  sample valid, per requester.
- `src_ready`  out  NREQ  sample accepted, per requester.
- `src_x_real`, `src_x_img`  in  16·NREQ  signed samples.
- `mc_in_valid`  out  1  drives core `in_valid`.
- `mc_x_real`, `mc_x_img`  out  16  drive core `x_real`/`x_img`.
- `mc_out_valid`  in  1  core `out_valid`.
- `mc_y_real`, `mc_y_img`  in  16  core results.
- `dst_valid`  out  1  result valid.
- `dst_id`  out  log2(NREQ)  owner of the result.
- `dst_y_real`, `dst_y_img`  out  16  result data.
- `dst_last`  out  1  marks the LEN-th result of a burst.
- `busy`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  one-cycle pulse on DRAIN timeout.

## Operation
FSM states and transitions:
- **IDLE**
  - With any `req` high, the arbiter picks `gnt`, registered, and the FSM goes to LOAD next cycle.
  - Priority starts at `last_gnt+1`. After reset, id 0 has highest priority.
- **LOAD**
  - `src_ready[gnt]`=1 and all other bits are 0.
  - A transfer occurs when `src_valid[gnt] & src_ready[gnt]`. Transferred samples are written to `buf[ld_cnt]`.
  - When the LEN-th sample is written, the FSM goes to FEED.
  - Deasserting `req` after grant is ignored: the burst is committed.
- **FEED**
  - For exactly LEN consecutive cycles: `mc_in_valid`=1, and `mc_x_*` = `buf[0..LEN-1]` in order.
  - Then the FSM goes to DRAIN.
- **DRAIN**
  - Waits until LEN core outputs have been received, then goes to IDLE.
  - `to_cnt` increments on each DRAIN cycle without `mc_out_valid` and clears on each output.
  - When `to_cnt` reaches TIMEOUT: `err_timeout` pulses, `last_gnt` updates, and the FSM goes to IDLE.

Results path:
- Core outputs are accepted in both FEED and DRAIN; `out_cnt` counts them.
- Each accepted output gives `dst_valid`=1 with `dst_id`=`gnt` and `dst_y_*`=`mc_y_*`.
- `dst_last`=1 on the output where `out_cnt`=LEN−1.
- Outputs in IDLE or LOAD, and outputs beyond LEN, are dropped: no `dst_valid`.

Arithmetic and widths:
- Data passes through untouched, no arithmetic on samples.
- Counters are `$clog2(LEN+1)` bits, except `to_cnt`, which is `$clog2(TIMEOUT+1)` bits.

## Timing
Reset values: all outputs 0; state=IDLE; `last_gnt`=NREQ−1; counters 0.

Latency and handshakes:
- `req` is sampled in IDLE at cycle t.
- `src_ready` is high from t+1.
- The first `mc_in_valid` is one cycle after the last LOAD transfer.
- `dst_*` is registered, one cycle after `mc_out_valid`.
- `busy` rises in the cycle after the grant.
- `busy` falls in the cycle after the LEN-th output is accepted: it drops together with `dst_last`.
- Back-to-back bursts cost a minimum of one IDLE cycle between DRAIN and LOAD.

Boundary conditions:
- **Single requester:** it is re-granted each round; no starvation.
- **All requesters asserting:** grants rotate 0,1,2,3,0…
- **`mc_out_valid` with the LEN-th sample in FEED:** accepted and counted.
- **Reset mid-burst:** `mc_in_valid` and `src_ready` drop at once; buffer contents are don't-care.
- **Core stall in DRAIN:** the timeout is the only exit.

## Structure
- Package `mc_pkg` holds:
  - state enum (IDLE/LOAD/FEED/DRAIN);
  - `MC_DW`=16;
  - packed complex sample type {real, img}.
- Sub-module `mc_rr_arb`: combinational round-robin arbiter (`req`, `last_gnt` → `gnt`, `gnt_vld`).
- Buffer: LEN×32 flop array in the top level.

## Test plan
1. **Single burst, stalls:** `req[2]`=1, 16 samples x=k+j(−k) with `src_valid` gaps every third cycle → `mc_in_valid` high for exactly 16 contiguous cycles, x in order; the model core returns 16 outputs → 16 `dst_valid` with `dst_id`=2 and `dst_last` on the 16th.
2. **Round-robin:** `req`=4'b1111 held for 8 bursts → grant order 0,1,2,3,0,1,2,3.
3. **Early output:** the core emits its first result during FEED cycle 10 → the result is accepted, `dst_id` is correct, and exactly 16 results are forwarded.
4. **Timeout:** the core returns only 5 outputs → `err_timeout` pulses 1024 cycles after the 5th output, then IDLE; the next burst proceeds normally.
5. **Reset mid-FEED:** assert `rst` at FEED index 7 → all outputs are 0 in the same cycle; after release, `req[0]` is granted first.
6. **Stray output:** `mc_out_valid` in IDLE → no `dst_valid`.
